// File: rtl/mcdt_arbiter.sv
// mcdt_arbiter: three-channel read arbiter for the multi-channel data
// transfer block. Each channel presents a FIFO non-empty request. The
// arbiter picks one winner (fixed priority or round robin), issues a
// one-cycle read ack, waits one cycle for the channel's read data valid
// and forwards the word with its source id. A missing valid raises a
// one-cycle error pulse and returns the arbiter to idle.
module mcdt_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,

    input  logic          slv0_req_i,
    input  logic          slv0_val_i,
    input  logic [DW-1:0] slv0_data_i,
    input  logic [1:0]    slv0_prio_i,

    input  logic          slv1_req_i,
    input  logic          slv1_val_i,
    input  logic [DW-1:0] slv1_data_i,
    input  logic [1:0]    slv1_prio_i,

    input  logic          slv2_req_i,
    input  logic          slv2_val_i,
    input  logic [DW-1:0] slv2_data_i,
    input  logic [1:0]    slv2_prio_i,

    input  logic          arb_mode_i,

    output logic          a2s0_ack_o,
    output logic          a2s1_ack_o,
    output logic          a2s2_ack_o,

    output logic [DW-1:0] arb_data_o,
    output logic          arb_val_o,
    output logic [1:0]    arb_id_o,
    output logic          arb_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    // Granted channel and the channel the round-robin search starts after.
    logic [1:0]    gnt_id_q;
    logic [1:0]    last_gnt_q;

    logic [2:0]    req_vec;
    logic [3:0]    val_vec;
    logic [5:0]    prio_vec;
    logic          any_req;
    logic          gnt_val;
    logic [1:0]    win_id;
    logic [DW-1:0] sel_data;

    // Decode strobes from the next-state logic.
    logic          arb_load;
    logic          data_load;
    logic          err_set;

    // Highest priority among requesters; ties resolve to the lowest index
    // because a later channel must be strictly higher to displace it.
    function automatic logic [1:0] pick_fixed(input logic [2:0] req,
                                              input logic [5:0] prio);
        logic [1:0] best_id;
        logic [1:0] best_p;
        logic       found;
        best_id = 2'd0;
        best_p  = 2'd0;
        found   = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (req[n] && (!found || (prio[2*n +: 2] > best_p))) begin
                best_id = 2'(n);
                best_p  = prio[2*n +: 2];
                found   = 1'b1;
            end
        end
        return best_id;
    endfunction

    // First requester found scanning upward from the channel after last.
    function automatic logic [1:0] pick_rr(input logic [2:0] req,
                                           input logic [1:0] last);
        logic [3:0] req_pad;
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        req_pad = {1'b0, req};
        idx     = (last >= 2'd2) ? 2'd0 : last + 2'd1;
        res     = 2'd0;
        found   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_pad[idx]) begin
                res   = idx;
                found = 1'b1;
            end
            idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return res;
    endfunction

    assign req_vec  = {slv2_req_i, slv1_req_i, slv0_req_i};
    assign val_vec  = {1'b0, slv2_val_i, slv1_val_i, slv0_val_i};
    assign prio_vec = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
    assign any_req  = |req_vec;

    // Only the granted channel's valid counts; stray valids are ignored.
    assign gnt_val  = val_vec[gnt_id_q];

    // Winner is evaluated every cycle but only registered on arb_load, so
    // mode and priority matter only in the arbitration cycle.
    assign win_id   = arb_mode_i ? pick_rr(req_vec, last_gnt_q)
                                 : pick_fixed(req_vec, prio_vec);

    // Read-data mux for the currently granted channel.
    always_comb begin
        case (gnt_id_q)
            2'd1:    sel_data = slv1_data_i;
            2'd2:    sel_data = slv2_data_i;
            default: sel_data = slv0_data_i;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic with arbitration, capture and error strobes.
    always_comb begin
        state_d   = state_q;
        arb_load  = 1'b0;
        data_load = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    arb_load = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (gnt_val) begin
                    data_load = 1'b1;
                    if (any_req) begin
                        arb_load = 1'b1;
                        state_d  = GRANT;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: the read ack is decoded purely from registered state.
    always_comb begin
        a2s0_ack_o = 1'b0;
        a2s1_ack_o = 1'b0;
        a2s2_ack_o = 1'b0;
        if (state_q == GRANT) begin
            case (gnt_id_q)
                2'd1:    a2s1_ack_o = 1'b1;
                2'd2:    a2s2_ack_o = 1'b1;
                default: a2s0_ack_o = 1'b1;
            endcase
        end
    end

    // Grant bookkeeping: both registers move together on every grant and
    // are left alone on an error so the next search order is unaffected.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gnt_id_q   <= 2'd0;
            last_gnt_q <= 2'd2;
        end else if (arb_load) begin
            gnt_id_q   <= win_id;
            last_gnt_q <= win_id;
        end
    end

    // Output pulses: valid and error are single-cycle strobes.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            arb_val_o <= 1'b0;
            arb_err_o <= 1'b0;
        end else begin
            arb_val_o <= data_load;
            arb_err_o <= err_set;
        end
    end

    // Output data and id hold their last value between valid pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            arb_data_o <= '0;
            arb_id_o   <= 2'd0;
        end else if (data_load) begin
            arb_data_o <= sel_data;
            arb_id_o   <= gnt_id_q;
        end
    end

    // Structural invariants of the handshake.
    a_ack_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0({a2s2_ack_o, a2s1_ack_o, a2s0_ack_o}));

    a_val_err_excl: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(arb_val_o && arb_err_o));

endmodule

// File: tb/tb_mcdt_arbiter.sv
// Bench for mcdt_arbiter: slave FIFO models answer acks with data one
// cycle later; expected {id, data} items are queued when stimulus is
// loaded and popped when arb_val_o pulses.
module tb_mcdt_arbiter;

    localparam int DW = 32;

    logic          clk_i;
    logic          rstn_i;
    logic [2:0]    s_req;
    logic [2:0]    s_val;
    logic [DW-1:0] s_dat [3];
    logic [1:0]    prio [3];
    logic          mode;

    logic          a2s0_ack_o;
    logic          a2s1_ack_o;
    logic          a2s2_ack_o;
    logic [DW-1:0] arb_data_o;
    logic          arb_val_o;
    logic [1:0]    arb_id_o;
    logic          arb_err_o;

    mcdt_arbiter #(.DW(DW)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .slv0_req_i  (s_req[0]),
        .slv0_val_i  (s_val[0]),
        .slv0_data_i (s_dat[0]),
        .slv0_prio_i (prio[0]),
        .slv1_req_i  (s_req[1]),
        .slv1_val_i  (s_val[1]),
        .slv1_data_i (s_dat[1]),
        .slv1_prio_i (prio[1]),
        .slv2_req_i  (s_req[2]),
        .slv2_val_i  (s_val[2]),
        .slv2_data_i (s_dat[2]),
        .slv2_prio_i (prio[2]),
        .arb_mode_i  (mode),
        .a2s0_ack_o  (a2s0_ack_o),
        .a2s1_ack_o  (a2s1_ack_o),
        .a2s2_ack_o  (a2s2_ack_o),
        .arb_data_o  (arb_data_o),
        .arb_val_o   (arb_val_o),
        .arb_id_o    (arb_id_o),
        .arb_err_o   (arb_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic            mode;
        logic [1:0]      p0;
        logic [1:0]      p1;
        logic [1:0]      p2;
        int              c0;
        int              c1;
        int              c2;
        int              n;
        logic [5:0][1:0] ids;
    } vec_t;

    exp_t          sbq [$];
    vec_t          vecs [8];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_ack_cyc = -100;
    int            last_val_cyc = -1;
    int            err_seen = 0;
    bit            chk_gap = 1'b0;

    // Slave model state.
    int            cnt [3];
    int            idx [3];
    bit            pend [3];
    logic [DW-1:0] pdat [3];
    bit            suppress [3];
    bit            stray0;

    function automatic logic [DW-1:0] word(input int ch, input int k);
        return 32'hA5A5_0000 + 32'(k << 8) + 32'(ch);
    endfunction

    function automatic logic [5:0][1:0] seq(input int a0, input int a1,
                                            input int a2, input int a3,
                                            input int a4, input int a5);
        logic [5:0][1:0] s;
        s[0] = 2'(a0); s[1] = 2'(a1); s[2] = 2'(a2);
        s[3] = 2'(a3); s[4] = 2'(a4); s[5] = 2'(a5);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int ch, input int k);
        exp_t e;
        e.id   = 2'(ch);
        e.data = word(ch, k);
        sbq.push_back(e);
    endtask

    task automatic drive();
        for (int n = 0; n < 3; n++) s_req[n] = (cnt[n] > 0);
    endtask

    task automatic clear_model();
        for (int n = 0; n < 3; n++) begin
            cnt[n]      = 0;
            idx[n]      = 0;
            pend[n]     = 1'b0;
            pdat[n]     = '0;
            suppress[n] = 1'b0;
            s_val[n]    = 1'b0;
            s_dat[n]    = '0;
            prio[n]     = 2'd0;
        end
        stray0       = 1'b0;
        mode         = 1'b0;
        last_ack_cyc = -100;
        last_val_cyc = -1;
        err_seen     = 0;
        sbq.delete();
        drive();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ack"}, {29'd0, a2s2_ack_o, a2s1_ack_o, a2s0_ack_o}, 32'd0);
        chk({nm, "_val"}, 32'(arb_val_o), 32'd0);
        chk({nm, "_err"}, 32'(arb_err_o), 32'd0);
        chk({nm, "_id"}, 32'(arb_id_o), 32'd0);
        chk({nm, "_data"}, arb_data_o, 32'd0);
    endtask

    // Observes DUT outputs at the falling edge.
    task automatic monitor();
        logic [2:0] ack;
        exp_t       e;
        ack = {a2s2_ack_o, a2s1_ack_o, a2s0_ack_o};
        chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        chk("val_err_excl", 32'(arb_val_o & arb_err_o), 32'd0);
        if (arb_val_o) begin
            if (sbq.size() == 0) begin
                chk("spurious_val", 32'(arb_val_o), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("arb_id", 32'(arb_id_o), 32'(e.id));
                chk("arb_data", arb_data_o, e.data);
            end
            chk("val_latency", 32'(cyc - last_ack_cyc), 32'd2);
            if (chk_gap && last_val_cyc >= 0)
                chk("val_gap", 32'(cyc - last_val_cyc), 32'd2);
            last_val_cyc = cyc;
        end
        if (arb_err_o) begin
            err_seen++;
            chk("err_latency", 32'(cyc - last_ack_cyc), 32'd2);
        end
        if (ack != 3'b000) last_ack_cyc = cyc;
    endtask

    // One clock: observe, then advance the slave FIFO models.
    task automatic step();
        logic [2:0] ack;
        @(negedge clk_i);
        cyc++;
        monitor();
        ack = {a2s2_ack_o, a2s1_ack_o, a2s0_ack_o};
        for (int n = 0; n < 3; n++) begin
            s_val[n] = pend[n] & ~suppress[n];
            s_dat[n] = pend[n] ? pdat[n] : '0;
            pend[n]  = ack[n];
            if (ack[n]) begin
                pdat[n] = word(n, idx[n]);
                idx[n]++;
                if (cnt[n] > 0) cnt[n]--;
            end
        end
        if (stray0 && !s_val[0]) begin
            s_val[0] = 1'b1;
            s_dat[0] = 32'hDEAD_BEEF;
        end
        drive();
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rstn_i = 1'b0;
        clear_model();
        repeat (2) step();
        rstn_i = 1'b1;
        last_val_cyc = -1;
        err_seen     = 0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sbq.size() > 0 && t < 100) begin
            step();
            t++;
        end
        chk({nm, "_drained"}, 32'(sbq.size()), 32'd0);
        repeat (4) step();
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int k [3];
        int id;
        apply_reset();
        mode    = v.mode;
        prio[0] = v.p0;
        prio[1] = v.p1;
        prio[2] = v.p2;
        k = '{0, 0, 0};
        for (int i = 0; i < v.n; i++) begin
            id = int'(v.ids[i]);
            push_exp(id, k[id]);
            k[id]++;
        end
        cnt[0] = v.c0;
        cnt[1] = v.c1;
        cnt[2] = v.c2;
        drive();
        chk_gap = 1'b1;
        drain($sformatf("vec%0d", vi));
        chk_gap = 1'b0;
        chk($sformatf("vec%0d_no_err", vi), 32'(err_seen), 32'd0);
    endtask

    initial begin
        int t;
        rstn_i = 1'b1;
        clear_model();
        #2 rstn_i = 1'b0;
        #1 chk_zero("por");
        repeat (3) step();
        rstn_i = 1'b1;
        repeat (3) step();
        chk("idle_no_ack", {29'd0, a2s2_ack_o, a2s1_ack_o, a2s0_ack_o}, 32'd0);

        // mode, prio0..2, words per channel, expected id order
        vecs[0] = '{1'b0, 2'd0, 2'd0, 2'd0, 0, 1, 0, 1, seq(1, 0, 0, 0, 0, 0)};
        vecs[1] = '{1'b0, 2'd1, 2'd3, 2'd3, 2, 2, 2, 6, seq(1, 1, 2, 2, 0, 0)};
        vecs[2] = '{1'b1, 2'd3, 2'd0, 2'd1, 2, 2, 2, 6, seq(0, 1, 2, 0, 1, 2)};
        vecs[3] = '{1'b0, 2'd2, 2'd2, 2'd1, 1, 1, 1, 3, seq(0, 1, 2, 0, 0, 0)};
        vecs[4] = '{1'b0, 2'd0, 2'd1, 2'd2, 1, 1, 1, 3, seq(2, 1, 0, 0, 0, 0)};
        vecs[5] = '{1'b1, 2'd0, 2'd0, 2'd3, 1, 0, 1, 2, seq(0, 2, 0, 0, 0, 0)};
        vecs[6] = '{1'b1, 2'd3, 2'd0, 2'd0, 0, 2, 1, 3, seq(1, 2, 1, 0, 0, 0)};
        vecs[7] = '{1'b0, 2'd3, 2'd3, 2'd3, 0, 0, 2, 2, seq(2, 2, 0, 0, 0, 0)};
        for (int vi = 0; vi < 8; vi++) run_vec(vecs[vi], vi);

        // Missing valid from channel 2, then normal service resumes.
        apply_reset();
        cnt[1] = 1;
        push_exp(1, 0);
        drive();
        drain("miss_pre");
        suppress[2] = 1'b1;
        cnt[2] = 1;
        drive();
        t = 0;
        while (err_seen == 0 && t < 20) begin
            step();
            t++;
        end
        repeat (4) step();
        chk("miss_err_once", 32'(err_seen), 32'd1);
        chk("miss_data_hold", arb_data_o, word(1, 0));
        chk("miss_id_hold", 32'(arb_id_o), 32'd1);
        err_seen    = 0;
        suppress[2] = 1'b0;
        cnt[2] = 1;
        push_exp(2, 1);
        drive();
        drain("miss_post");
        chk("miss_post_no_err", 32'(err_seen), 32'd0);

        // Reset asserted while waiting for valid aborts silently.
        apply_reset();
        mode   = 1'b1;
        cnt[1] = 1;
        push_exp(1, 0);
        drive();
        drain("rst_pre");
        cnt[1] = 1;
        drive();
        t = 0;
        while (!a2s1_ack_o && t < 20) begin
            step();
            t++;
        end
        chk("rst_ack_seen", 32'(a2s1_ack_o), 32'd1);
        step();
        rstn_i = 1'b0;
        #1 chk_zero("rst_mid");
        clear_model();
        repeat (2) step();
        rstn_i = 1'b1;
        mode   = 1'b1;
        cnt[0] = 1;
        cnt[2] = 1;
        push_exp(0, 0);
        push_exp(2, 0);
        drive();
        drain("rst_post");
        chk("rst_no_err", 32'(err_seen), 32'd0);

        // Stray valid from channel 0 while channel 1 is granted.
        apply_reset();
        stray0 = 1'b1;
        cnt[1] = 1;
        push_exp(1, 0);
        drive();
        drain("stray");
        stray0 = 1'b0;
        chk("stray_no_err", 32'(err_seen), 32'd0);
        chk("stray_id", 32'(arb_id_o), 32'd1);
        chk("stray_data", arb_data_o, word(1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
